c1_bus_master_arb: RTL and testbench
====================================

C1_BUS_MASTER_ARB -- requirements
Module: c1_bus_master_arb

Interface
REQ-001 Parameters, one per line, SHALL be:
- MEM_ADDR_SIZE, 19, byte address width
- BUS_SIZE, 16, C1 data bus width
- CACHE_OFFSET_SIZE, 4, line offset width
- TIMEOUT, 255, maximum response-wait cycles
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- reqN (N=0,1)  in  1  requester N transaction request
- opN  in  3  C1 command code: 1 R8, 2 R16, 3 R32, 4 INV, 5 W8, 6 W16, 7 W32
- addrN  in  MEM_ADDR_SIZE  byte address
- wdataN  in  2*BUS_SIZE  write data
- doneN  out  1  one-cycle completion pulse
- errN  out  1  timeout flag, valid with doneN
- rdataN  out  2*BUS_SIZE  read data, valid with doneN
- address  out  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address bus, Z when not driven
- data  inout  BUS_SIZE  C1 data bus
- command  inout  3  C1 command bus

Function
REQ-003 The block SHALL serialize two requesters onto one C1 bus, one transaction at a time.
REQ-004 Requester handshake: reqN, opN, addrN and wdataN held stable until doneN; the requester deasserts reqN or presents a new request in the cycle after doneN.
REQ-005 Arbitration SHALL be round-robin, evaluated only in IDLE; the last-served requester has lower priority; after reset requester 0 has priority.
REQ-006 States: IDLE, ADDR1, ADDR2, WAIT, DATA2, TURN.
REQ-007 IDLE, a request present: latch the winner's op/addr/wdata and go to ADDR1; a request with op 0 SHALL instead pulse doneN the next cycle with no bus activity.
REQ-008 ADDR1: drive command=op and address=addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE]; go to ADDR2.
REQ-009 ADDR2: drive command=op and address={zeros, addr[CACHE_OFFSET_SIZE-1:0]}; go to WAIT.
REQ-010 Write data: W8 drives {8'b0, wdata[7:0]} and W16 drives wdata[15:0] in both ADDR1 and ADDR2; W32 drives wdata[15:0] in ADDR1 and wdata[31:16] in ADDR2; reads and INV never drive data.
REQ-011 From WAIT onward, command, address and data SHALL be released to Z.
REQ-012 WAIT: leave on the first cycle command==3'd7 (response); reads sample data that cycle.
REQ-013 After the response: R32 goes to DATA2 and samples the high word the next cycle; all other ops go to TURN.
REQ-014 Read result: R8 returns {24'b0, data[7:0]}; R16 returns {16'b0, data}; R32 returns {high, low}; writes and INV return 0.
REQ-015 TURN: doneN pulses for exactly one cycle with rdataN/errN valid; the block returns to IDLE next cycle; the bus stays released.
REQ-016 Latency: request seen in IDLE at cycle T gives ADDR1 at T+1; a response at cycle R gives doneN at R+1 (R+2 for R32); next grant no earlier than done+1.
REQ-017 Timeout: WAIT counter reaching TIMEOUT with no response SHALL go to TURN with errN=1 and rdataN=0.
REQ-018 Requester deassertion mid-transaction SHALL be ignored; the transaction completes.
REQ-019 Simultaneous req0 and req1 in IDLE: the priority holder is granted and the other waits.

Reset
REQ-020 reset sampled high SHALL, by the next edge, force: IDLE; all buses Z; doneN=0, errN=0, rdataN=0; timeout counter 0; priority to requester 0. This applies mid-transaction, with no completion pulse.

Verification
REQ-021 R8 from req0, addr 19'b0000000000_01110_0000, cache responds 4 cycles after ADDR2 with data 16'h00F0 -> command 1 in ADDR1/ADDR2 with address 15'b000000000001110 then 15'b0, done0 with rdata0=32'h000000F0.
REQ-022 W32 from req1, wdata 32'h55555555 -> data 16'h5555 in ADDR1 and ADDR2, command 7 on both, bus Z in WAIT, done1 one cycle after the response, rdata1=0.
REQ-023 R32, response words 16'h0F0F then 16'hF0F0 on consecutive cycles -> rdata=32'hF0F00F0F, done two cycles after the first response word.
REQ-024 req0 and req1 asserted together three times back-to-back -> grant order 0,1,0, no cycle with both doneN high.
REQ-025 No response, TIMEOUT=8 -> doneN with errN=1 and rdata=0 after 8 WAIT cycles.
REQ-026 reset asserted during WAIT -> next cycle all buses Z, state IDLE, no doneN pulse.

Source files
------------

// File: rtl/c1_bus_master_arb.sv
// Round-robin arbiter that serializes two requesters onto one C1 bus, one transaction at a time.
// Request in IDLE -> ADDR1 next cycle; done one cycle after response (two for R32); done+1 before next grant.
module c1_bus_master_arb #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT           = 255
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req0,
    input  logic [2:0]                                op0,
    input  logic [MEM_ADDR_SIZE-1:0]                  addr0,
    input  logic [2*BUS_SIZE-1:0]                     wdata0,
    output logic                                      done0,
    output logic                                      err0,
    output logic [2*BUS_SIZE-1:0]                     rdata0,
    input  logic                                      req1,
    input  logic [2:0]                                op1,
    input  logic [MEM_ADDR_SIZE-1:0]                  addr1,
    input  logic [2*BUS_SIZE-1:0]                     wdata1,
    output logic                                      done1,
    output logic                                      err1,
    output logic [2*BUS_SIZE-1:0]                     rdata1,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                       data,
    inout  wire  [2:0]                                command
);

    localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int DW = 2 * BUS_SIZE;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_R8   = 3'd1;
    localparam logic [2:0] OP_R16  = 3'd2;
    localparam logic [2:0] OP_R32  = 3'd3;
    localparam logic [2:0] OP_W8   = 3'd5;
    localparam logic [2:0] OP_W16  = 3'd6;
    localparam logic [2:0] OP_W32  = 3'd7;
    localparam logic [2:0] CMD_RESP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR1,
        S_ADDR2,
        S_WAIT,
        S_DATA2,
        S_TURN
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     owner;
    logic                     prio;
    logic [2:0]               op_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [DW-1:0]            wdata_q;
    logic [DW-1:0]            result_q;
    logic                     err_q;
    logic [CW-1:0]            cnt;

    logic                     grant;
    logic [2:0]               grant_op;
    logic                     resp;
    logic                     tmo;
    logic                     drive_bus;
    logic                     drive_data;
    logic [AW-1:0]            addr_word;
    logic [BUS_SIZE-1:0]      wr_word;
    logic [DW-1:0]            rd_word;

    always_comb begin
        next_state = state;
        grant      = (req0 && req1) ? prio : req1;
        grant_op   = grant ? op1 : op0;
        resp       = (command == CMD_RESP);
        tmo        = (cnt == CNT_LAST);
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    // op 0 is a no-op: complete without touching the bus
                    next_state = (grant_op == OP_NONE) ? S_TURN : S_ADDR1;
                end
            end
            S_ADDR1: next_state = S_ADDR2;
            S_ADDR2: next_state = S_WAIT;
            S_WAIT: begin
                if (resp) begin
                    next_state = (op_q == OP_R32) ? S_DATA2 : S_TURN;
                end else if (tmo) begin
                    next_state = S_TURN;
                end
            end
            S_DATA2: next_state = S_TURN;
            S_TURN:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        case (op_q)
            OP_R8:          rd_word = {{(DW-8){1'b0}}, data[7:0]};
            OP_R16, OP_R32: rd_word = {{BUS_SIZE{1'b0}}, data};
            default:        rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            prio     <= 1'b0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner    <= grant;
                        prio     <= ~grant;
                        op_q     <= grant_op;
                        addr_q   <= grant ? addr1 : addr0;
                        wdata_q  <= grant ? wdata1 : wdata0;
                        result_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_ADDR2: cnt <= '0;
                S_WAIT: begin
                    if (resp) begin
                        result_q <= rd_word;
                    end else if (tmo) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA2: result_q[DW-1:BUS_SIZE] <= data;
                default: ;
            endcase
        end
    end

    // Bus is owned only during the two address phases; released from WAIT onward.
    always_comb begin
        drive_bus  = (state == S_ADDR1) || (state == S_ADDR2);
        drive_data = drive_bus && ((op_q == OP_W8) || (op_q == OP_W16) || (op_q == OP_W32));
        addr_word  = (state == S_ADDR1) ? addr_q[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE]
                                        : {{(AW-CACHE_OFFSET_SIZE){1'b0}}, addr_q[CACHE_OFFSET_SIZE-1:0]};
        wr_word    = wdata_q[BUS_SIZE-1:0];
        if (op_q == OP_W8) begin
            wr_word = {{(BUS_SIZE-8){1'b0}}, wdata_q[7:0]};
        end else if (op_q == OP_W32 && state == S_ADDR2) begin
            wr_word = wdata_q[DW-1:BUS_SIZE];
        end
    end

    assign address = drive_bus  ? addr_word : {AW{1'bz}};
    assign command = drive_bus  ? op_q      : 3'bzzz;
    assign data    = drive_data ? wr_word   : {BUS_SIZE{1'bz}};

    assign done0  = (state == S_TURN) && !owner;
    assign done1  = (state == S_TURN) && owner;
    assign err0   = done0 && err_q;
    assign err1   = done1 && err_q;
    assign rdata0 = done0 ? result_q : '0;
    assign rdata1 = done1 ? result_q : '0;

endmodule

// File: tb/tb_c1_bus_master_arb.sv
// Bench for c1_bus_master_arb: directed cases then random traffic against a cycle-count reference model.
module tb_c1_bus_master_arb;

    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [18:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    wire  [14:0] address;
    wire  [15:0] data;
    wire  [2:0]  command;

    logic        tb_den, tb_cen;
    logic [15:0] tb_d;
    logic [2:0]  tb_c;

    assign data    = tb_den ? tb_d : 16'bz;
    assign command = tb_cen ? tb_c : 3'bz;

    c1_bus_master_arb #(
        .MEM_ADDR_SIZE(19), .BUS_SIZE(16), .CACHE_OFFSET_SIZE(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .err1(err1), .rdata1(rdata1),
        .address(address), .data(data), .command(command)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pending request per requester and round-robin priority holder
    logic        pend [2];
    logic [2:0]  m_op [2];
    logic [18:0] m_addr [2];
    logic [31:0] m_wd [2];
    int          prio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic apply_reqs();
        req0 = pend[0]; op0 = m_op[0]; addr0 = m_addr[0]; wdata0 = m_wd[0];
        req1 = pend[1]; op1 = m_op[1]; addr1 = m_addr[1]; wdata1 = m_wd[1];
    endtask

    task automatic new_req(input int n, input logic [2:0] op, input logic [18:0] a, input logic [31:0] wd);
        pend[n] = 1'b1; m_op[n] = op; m_addr[n] = a; m_wd[n] = wd;
    endtask

    // Called just after a negedge with the block idle at the next posedge.
    // d: WAIT cycle index of the cache response (d >= TMO means no response).
    task automatic round(input int d, input logic [15:0] lo, input logic [15:0] hi);
        int          w, dn, last;
        logic [31:0] er;
        logic        ee;
        logic [2:0]  op;
        logic [18:0] a;
        logic [31:0] wd;
        logic [15:0] exp_d;
        apply_reqs();
        w    = (pend[0] && pend[1]) ? prio : (pend[0] ? 0 : 1);
        prio = 1 - w;
        op = m_op[w]; a = m_addr[w]; wd = m_wd[w];
        ee = 1'b0; er = 32'h0;
        if (op == 3'd0) begin
            dn = 0;
        end else if (d >= TMO) begin
            dn = 2 + TMO; ee = 1'b1;
        end else begin
            dn = (op == 3'd3) ? 4 + d : 3 + d;
            case (op)
                3'd1:    er = {24'h0, lo[7:0]};
                3'd2:    er = {16'h0, lo};
                3'd3:    er = {hi, lo};
                default: er = 32'h0;
            endcase
        end
        last = (d < TMO) ? d : TMO - 1;
        for (int j = 0; j <= dn; j++) begin
            @(negedge clk);
            check("done_winner", w ? done1 : done0, j == dn);
            check("done_other", w ? done0 : done1, 1'b0);
            if (j == dn) begin
                check("rdata", w ? rdata1 : rdata0, er);
                check("err", w ? err1 : err0, ee);
                pend[w] = 1'b0;
                apply_reqs();
            end
            if (op != 3'd0 && j < 2) begin
                check("cmd_addr_phase", command, op);
                check("address", address, (j == 0) ? a[18:4] : {11'h0, a[3:0]});
                if (op >= 3'd5) begin
                    exp_d = (op == 3'd5) ? {8'h0, wd[7:0]} :
                            (op == 3'd7 && j == 1) ? wd[31:16] : wd[15:0];
                    check("wdata_bus", data, exp_d);
                end
            end
            tb_den = 1'b0; tb_cen = 1'b0;
            if (op != 3'd0 && j >= 2 && j - 2 <= last) begin
                tb_cen = 1'b1; tb_den = 1'b1;
                tb_c = (j - 2 == d) ? 3'd7 : 3'd0;
                tb_d = (j - 2 == d) ? lo : 16'($urandom);
            end else if (op == 3'd3 && d < TMO && j == 3 + d) begin
                tb_den = 1'b1; tb_d = hi;
            end
            if (op != 3'd0 && j == 2) begin
                #1;
                check("bus_released", data, tb_d);
            end
        end
        tb_den = 1'b0; tb_cen = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_req(input int n);
        new_req(n, 3'($urandom_range(0, 7)), 19'($urandom), $urandom);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        tb_den = 1'b0; tb_cen = 1'b0; tb_d = '0; tb_c = '0;
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; m_op[n] = '0; m_addr[n] = '0; m_wd[n] = '0;
        end
        prio = 0;
        apply_reqs();
        repeat (3) @(negedge clk);
        check("rst_done0", done0, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_err0", err0, 1'b0);
        check("rst_err1", err1, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // R8 read, cache answers on the fifth WAIT cycle
        new_req(0, 3'd1, 19'b0000000000_01110_0000, 32'h0);
        round(4, 16'h00F0, 16'h0);
        // W32 write from requester 1
        new_req(1, 3'd7, 19'h2A5C3, 32'h55555555);
        round(3, 16'h1234, 16'h0);
        // R32 two-word read
        new_req(0, 3'd3, 19'h1F00F, 32'h0);
        round(2, 16'h0F0F, 16'hF0F0);
        // no response: timeout
        new_req(1, 3'd2, 19'h00011, 32'h0);
        round(TMO, 16'hAAAA, 16'h0);
        // op 0: immediate completion
        new_req(0, 3'd0, 19'h7FFFF, 32'hDEADBEEF);
        round(0, 16'h0, 16'h0);

        // Reset while waiting for the cache
        new_req(0, 3'd2, 19'h12345, 32'h0);
        apply_reqs();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("pre_rst_done0", done0, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pend[0] = 1'b0;
        apply_reqs();
        prio = 0;
        for (int j = 0; j < 3; j++) begin
            check("midrst_done0", done0, 1'b0);
            check("midrst_done1", done1, 1'b0);
            check("midrst_rdata0", rdata0, 32'h0);
            check("midrst_err0", err0, 1'b0);
            @(negedge clk);
        end

        // Both requesting, three rounds back to back: expect 0,1,0
        rand_req(0);
        rand_req(1);
        for (int k = 0; k < 3; k++) begin
            round($urandom_range(0, 3), 16'($urandom), 16'($urandom));
            for (int n = 0; n < 2; n++) if (!pend[n]) rand_req(n);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        apply_reqs();
        @(negedge clk);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            for (int n = 0; n < 2; n++) if (!pend[n] && $urandom_range(0, 1) == 1) rand_req(n);
            if (!pend[0] && !pend[1]) rand_req($urandom_range(0, 1));
            round($urandom_range(0, TMO + 1), 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
